psg_multichannel: RTL

//   Parametrised PSG core: NCH square-wave tone channels sharing one 17-bit noise LFSR and one
//   YM-style envelope generator, with per-channel stereo panning and registered L/R mix outputs.

---
 rtl/psg_multichannel.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/psg_multichannel.sv
// Multi-channel PSG core: NCH square-wave tone channels, a shared 17-bit noise
// LFSR and a YM-style envelope generator, with per-channel L/R panning and
// registered stereo mix outputs. Programmed over the AY bus (BDIR/BC).
module psg_multichannel #(
  parameter  int NCH = 3,
  parameter  int TW  = 12,
  parameter  int EW  = 16,
  localparam int AW  = $clog2(4*NCH+4),
  localparam int OW  = 8 + $clog2(NCH+1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CE,
  input  logic          BDIR,
  input  logic          BC,
  input  logic [7:0]    DI,
  output logic [7:0]    DO,
  input  logic          SEL,
  input  logic          MODE,
  output logic [OW-1:0] OUT_L,
  output logic [OW-1:0] OUT_R,
  output logic [NCH-1:0] ACTIVE
);

  // High period bytes are stored pre-masked so reads and compares see only valid bits.
  localparam logic [7:0] TMASK = 8'((1 << (TW-8)) - 1);
  localparam logic [7:0] EMASK = 8'((1 << (EW-8)) - 1);

  localparam logic [7:0] YM_TAB [32] = '{
    8'd0,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
    8'd5,   8'd6,   8'd7,   8'd8,   8'd10,  8'd11,  8'd13,  8'd16,
    8'd19,  8'd23,  8'd27,  8'd32,  8'd38,  8'd45,  8'd54,  8'd64,
    8'd76,  8'd90,  8'd107, 8'd128, 8'd152, 8'd180, 8'd214, 8'd255
  };
  localparam logic [7:0] AY_TAB [16] = '{
    8'd0,   8'd2,   8'd3,   8'd4,   8'd6,   8'd8,   8'd11,  8'd16,
    8'd23,  8'd32,  8'd45,  8'd64,  8'd90,  8'd128, 8'd180, 8'd255
  };

  // Register file
  logic [AW-1:0] addr;
  logic [7:0]    per_lo [NCH];
  logic [7:0]    per_hi [NCH];
  logic [4:0]    vreg   [NCH];
  logic [3:0]    ctrl   [NCH];
  logic [4:0]    nper;
  logic [7:0]    eper_lo;
  logic [7:0]    eper_hi;
  logic [3:0]    shape;

  // Generator state
  logic          bdir_q;
  logic [3:0]    pre_cnt;
  logic          nphase;
  logic [TW-1:0] tcnt [NCH];
  logic [NCH-1:0] sq;
  logic [4:0]    ncnt;
  logic [16:0]   lfsr;
  logic [EW-1:0] ecnt;
  logic [4:0]    env_vol;
  logic          env_up;
  logic          env_hold;
  logic          restart;
  logic [7:0]    lvl_l_q [NCH];
  logic [7:0]    lvl_r_q [NCH];

  // Combinational helpers
  logic          acc;
  logic          shape_wr;
  logic          tick;
  logic          ntick;
  logic [15:0]   tper_m1 [NCH];
  logic [15:0]   eper_m1;
  logic [4:0]    nper_m1;
  logic [4:0]    ev_n;
  logic          eu_n;
  logic          eh_n;
  logic [7:0]    lvl8 [NCH];
  logic [7:0]    do_r;
  logic [OW-1:0] sum_l;
  logic [OW-1:0] sum_r;

  assign acc      = BDIR & ~bdir_q;
  assign shape_wr = acc & ~BC & ~RESET & (addr == AW'(4*NCH+3));
  assign tick     = CE & (pre_cnt == 4'd0);
  assign ntick    = tick & nphase;
  assign DO       = do_r;

  // BDIR edge detector; left out of reset so a held BDIR cannot fake a new access.
  always_ff @(posedge CLK) begin
    bdir_q <= BDIR;
  end

  // Bus side: address latch and register writes (reset takes priority).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr    <= '0;
      nper    <= '0;
      eper_lo <= '0;
      eper_hi <= '0;
      shape   <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        per_lo[i] <= '0;
        per_hi[i] <= '0;
        vreg[i]   <= '0;
        ctrl[i]   <= '1;
      end
    end else if (acc) begin
      if (BC) begin
        addr <= DI[AW-1:0];
      end else begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (addr == AW'(4*i))   per_lo[i] <= DI;
          if (addr == AW'(4*i+1)) per_hi[i] <= DI & TMASK;
          if (addr == AW'(4*i+2)) vreg[i]   <= DI[4:0];
          if (addr == AW'(4*i+3)) ctrl[i]   <= DI[3:0];
        end
        if (addr == AW'(4*NCH))   nper    <= DI[4:0];
        if (addr == AW'(4*NCH+1)) eper_lo <= DI;
        if (addr == AW'(4*NCH+2)) eper_hi <= DI & EMASK;
        if (addr == AW'(4*NCH+3)) shape   <= DI[3:0];
      end
    end
  end

  // Read mux: unmapped addresses return zero.
  always_comb begin
    do_r = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (addr == AW'(4*i))   do_r = per_lo[i];
      if (addr == AW'(4*i+1)) do_r = per_hi[i];
      if (addr == AW'(4*i+2)) do_r = {3'b000, vreg[i]};
      if (addr == AW'(4*i+3)) do_r = {4'b0000, ctrl[i]};
    end
    if (addr == AW'(4*NCH))   do_r = {3'b000, nper};
    if (addr == AW'(4*NCH+1)) do_r = eper_lo;
    if (addr == AW'(4*NCH+2)) do_r = eper_hi;
    if (addr == AW'(4*NCH+3)) do_r = {4'b0000, shape};
  end

  // Period-minus-one compare values (period 0 behaves as 1) and envelope step.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      tper_m1[i] = ({per_hi[i], per_lo[i]} == 16'd0) ? 16'd0 : {per_hi[i], per_lo[i]} - 16'd1;
      ACTIVE[i]  = ~(ctrl[i][0] & ctrl[i][1]);
    end
    eper_m1 = ({eper_hi, eper_lo} == 16'd0) ? 16'd0 : {eper_hi, eper_lo} - 16'd1;
    nper_m1 = (nper == 5'd0) ? 5'd0 : nper - 5'd1;
    ev_n = env_vol;
    eu_n = env_up;
    eh_n = env_hold;
    if (env_up ? (env_vol == 5'd31) : (env_vol == 5'd0)) begin
      if (!shape[3]) begin
        eh_n = 1'b1;
        ev_n = 5'd0;
      end else if (shape[0]) begin
        eh_n = 1'b1;
        ev_n = shape[1] ? ~env_vol : env_vol;
      end else if (shape[1]) begin
        eu_n = ~env_up;
        ev_n = env_up ? 5'd30 : 5'd1;
      end else begin
        ev_n = env_up ? 5'd0 : 5'd31;
      end
    end else begin
      ev_n = env_up ? env_vol + 5'd1 : env_vol - 5'd1;
    end
  end

  // Prescaler, tone counters, noise LFSR and envelope; all frozen while CE is low.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_cnt  <= '0;
      nphase   <= 1'b0;
      sq       <= '0;
      ncnt     <= '0;
      lfsr     <= '0;
      ecnt     <= '0;
      env_vol  <= '0;
      env_up   <= 1'b0;
      env_hold <= 1'b1;
      restart  <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) tcnt[i] <= '0;
    end else begin
      if (CE) begin
        pre_cnt <= (pre_cnt == 4'd0) ? {SEL, 3'b111} : pre_cnt - 4'd1;
      end
      if (tick) begin
        nphase <= ~nphase;
        for (int unsigned i = 0; i < NCH; i++) begin
          if (16'(tcnt[i]) >= tper_m1[i]) begin
            tcnt[i] <= '0;
            sq[i]   <= ~sq[i];
          end else begin
            tcnt[i] <= tcnt[i] + 1'b1;
          end
        end
      end
      if (ntick) begin
        if (ncnt >= nper_m1) begin
          ncnt <= '0;
          lfsr <= {lfsr[0] ^ lfsr[2] ^ (lfsr == 17'd0), lfsr[16:1]};
        end else begin
          ncnt <= ncnt + 5'd1;
        end
      end
      // A pending restart consumes its CE instead of an envelope step.
      if (CE && restart) begin
        env_vol  <= shape[2] ? 5'd0 : 5'd31;
        env_up   <= shape[2];
        env_hold <= 1'b0;
        ecnt     <= '0;
        restart  <= 1'b0;
      end else if (tick && !env_hold) begin
        if (16'(ecnt) >= eper_m1) begin
          ecnt     <= '0;
          env_vol  <= ev_n;
          env_up   <= eu_n;
          env_hold <= eh_n;
        end else begin
          ecnt <= ecnt + 1'b1;
        end
      end
      if (shape_wr) restart <= 1'b1;
    end
  end

  // Per-channel gating and volume lookup.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      logic       g;
      logic [4:0] level;
      g       = (ctrl[i][0] | sq[i]) & (ctrl[i][1] | lfsr[0]);
      level   = g ? (vreg[i][4] ? env_vol : {vreg[i][3:0], vreg[i][3]}) : 5'd0;
      lvl8[i] = MODE ? AY_TAB[level[4:1]] : YM_TAB[level];
    end
  end

  // Stereo sums of the registered, panned channel levels.
  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      sum_l = sum_l + OW'(lvl_l_q[i]);
      sum_r = sum_r + OW'(lvl_r_q[i]);
    end
  end

  // Two-stage mix pipeline: panned levels, then registered L/R sums.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_L <= '0;
      OUT_R <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        lvl_l_q[i] <= '0;
        lvl_r_q[i] <= '0;
      end
    end else if (CE) begin
      OUT_L <= sum_l;
      OUT_R <= sum_r;
      for (int unsigned i = 0; i < NCH; i++) begin
        lvl_l_q[i] <= ctrl[i][2] ? lvl8[i] : 8'd0;
        lvl_r_q[i] <= ctrl[i][3] ? lvl8[i] : 8'd0;
      end
    end
  end

endmodule
